// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and the ALU datapath.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_OR  = 3'b100,
        OP_AND = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two issue sources and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int bits = 32
) ();
    logic [1:0]      req_valid_i;
    logic [1:0]      req_ready_o;
    logic [bits-1:0] req_a_i  [2];
    logic [bits-1:0] req_b_i  [2];
    logic [2:0]      req_op_i [2];
    logic [1:0]      rsp_valid_o;
    logic [1:0]      rsp_ready_i;
    logic [bits-1:0] rsp_result_o;
    logic [3:0]      rsp_flags_o;
    logic            busy_o;

    // Requester side
    modport master (
        output req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o, busy_o
    );

    // Arbiter side
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o, busy_o
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU: eight operations plus signed overflow for ADD/SUB.
module alu
    import alu_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic [bits-1:0] a_i,
    input  logic [bits-1:0] b_i,
    input  alu_op_e         op_i,
    output logic [bits-1:0] result_o,
    output logic            overflow_o
);
    // A bits-wide field always holds the value bits, so the compare is exact.
    localparam logic [bits-1:0] BITS_V = bits[bits-1:0];

    logic shift_oor;

    // Operation select; shifts by bits or more flush to zero.
    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        shift_oor  = (b_i >= BITS_V);
        case (op_i)
            OP_ADD: begin
                result_o   = a_i + b_i;
                overflow_o = (a_i[bits-1] == b_i[bits-1]) && (result_o[bits-1] != a_i[bits-1]);
            end
            OP_SUB: begin
                result_o   = a_i - b_i;
                overflow_o = (a_i[bits-1] != b_i[bits-1]) && (result_o[bits-1] != a_i[bits-1]);
            end
            OP_SHL:  result_o = shift_oor ? '0 : (a_i << b_i);
            OP_SHR:  result_o = shift_oor ? '0 : (a_i >> b_i);
            OP_OR:   result_o = a_i | b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            default: result_o = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter2.sv
// Two-way grant: a lone valid wins outright, a tie is broken by the pointer.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       gnt_id_o,
    output logic       any_o
);
    // Grant selection
    always_comb begin
        any_o    = |valid_i;
        gnt_id_o = (valid_i == 2'b11) ? ptr_i : valid_i[1];
        grant_o  = any_o ? (2'b01 << gnt_id_o) : 2'b00;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: accept, execute one cycle, respond.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_arbiter_if.slave  bus
);
    arb_state_e      state_q, state_d;
    logic            rr_q, rr_d;
    logic            id_q, id_d;
    logic [bits-1:0] a_q, a_d;
    logic [bits-1:0] b_q, b_d;
    alu_op_e         op_q, op_d;
    logic [bits-1:0] result_q, result_d;
    logic [3:0]      flags_q, flags_d;

    logic [1:0]      grant;
    logic            gnt_id;
    logic            any_valid;
    logic [bits-1:0] alu_result;
    logic            alu_ovf;
    logic [bits:0]   sum_w;
    logic [bits:0]   diff_w;
    logic            carry;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;

    // Carry and overflow only mean something for ADD/SUB; masked otherwise.
    function automatic logic [3:0] make_flags(input logic [bits-1:0] res,
                                              input logic c, input logic v,
                                              input alu_op_e op);
        logic [3:0] f;
        logic       arith;
        arith     = (op == OP_ADD) || (op == OP_SUB);
        f         = '0;
        f[FLAG_N] = res[bits-1];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = arith & c;
        f[FLAG_V] = arith & v;
        return f;
    endfunction

    rr_arbiter2 u_rr (
        .valid_i  (bus.req_valid_i),
        .ptr_i    (rr_q),
        .grant_o  (grant),
        .gnt_id_o (gnt_id),
        .any_o    (any_valid)
    );

    alu #(.bits(bits)) u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .op_i       (op_q),
        .result_o   (alu_result),
        .overflow_o (alu_ovf)
    );

    // Carry-out of the bits+1 wide sum; SUB carry=1 means no borrow.
    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} + {1'b0, ~b_q} + (bits+1)'(1);
        carry  = (op_q == OP_SUB) ? diff_w[bits] : sum_w[bits];
    end

    // Next-state and handshake outputs of the IDLE/EXEC/RESP controller.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        flags_d   = flags_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    req_ready = grant;
                    a_d       = bus.req_a_i[gnt_id];
                    b_d       = bus.req_b_i[gnt_id];
                    op_d      = alu_op_e'(bus.req_op_i[gnt_id]);
                    id_d      = gnt_id;
                    rr_d      = ~gnt_id;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                flags_d  = make_flags(alu_result, carry, alu_ovf, op_q);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 2'b01 << id_q;
                if (bus.rsp_ready_i[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Operand registers; only meaningful once a grant has loaded them.
    always_ff @(posedge clk_i) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    // Outputs forced to their idle values while reset is asserted.
    always_comb begin
        bus.req_ready_o  = rst_i ? 2'b00 : req_ready;
        bus.rsp_valid_o  = rst_i ? 2'b00 : rsp_valid;
        bus.rsp_result_o = result_q;
        bus.rsp_flags_o  = flags_q;
        bus.busy_o       = (state_q != ST_IDLE);
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter at 8-bit width.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.bits(W)) bus ();

    alu_arbiter #(.bits(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rid;
        alu_op_e       op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  res;
        logic [3:0]    flags;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i = 2'b00;
        bus.rsp_ready_i = 2'b00;
        for (int r = 0; r < 2; r++) begin
            bus.req_a_i[r]  = '0;
            bus.req_b_i[r]  = '0;
            bus.req_op_i[r] = 3'b000;
        end
    endtask

    task automatic load(input logic rid, input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a_i[rid]  = a;
        bus.req_b_i[rid]  = b;
        bus.req_op_i[rid] = op;
    endtask

    // One transaction on a single requester with response ready held high.
    task automatic run_txn(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        load(v.rid, v.op, v.a, v.b);
        bus.req_valid_i = 2'b01 << v.rid;
        bus.rsp_ready_i = 2'b11;
        #1;
        chk({tag, "_ready"}, bus.req_ready_o, 2'b01 << v.rid);
        chk({tag, "_busy_idle"}, bus.busy_o, 1'b0);
        tick();
        bus.req_valid_i = 2'b00;
        #1;
        chk({tag, "_exec_vld"}, bus.rsp_valid_o, 2'b00);
        chk({tag, "_exec_busy"}, bus.busy_o, 1'b1);
        tick();
        chk({tag, "_rsp_vld"}, bus.rsp_valid_o, 2'b01 << v.rid);
        chk({tag, "_res"}, bus.rsp_result_o, v.res);
        chk({tag, "_flags"}, bus.rsp_flags_o, v.flags);
        tick();
        chk({tag, "_back_idle"}, bus.busy_o, 1'b0);
    endtask

    logic [W-1:0] c_res   [3];
    logic [3:0]   c_flags [3];
    logic         c_gnt   [3];

    initial begin
        //            rid   op      a      b      res    NZCV
        vecs[0]  = '{1'b0, OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001};
        vecs[1]  = '{1'b1, OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0110};
        vecs[2]  = '{1'b0, OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b1000};
        vecs[3]  = '{1'b1, OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0011};
        vecs[4]  = '{1'b0, OP_SHL, 8'h03, 8'h02, 8'h0C, 4'b0000};
        vecs[5]  = '{1'b1, OP_SHR, 8'hFF, 8'h08, 8'h00, 4'b0100};
        vecs[6]  = '{1'b0, OP_SHR, 8'h80, 8'h07, 8'h01, 4'b0000};
        vecs[7]  = '{1'b1, OP_SHL, 8'hFF, 8'h01, 8'hFE, 4'b1000};
        vecs[8]  = '{1'b0, OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b1000};
        vecs[9]  = '{1'b1, OP_AND, 8'hF0, 8'h0F, 8'h00, 4'b0100};
        vecs[10] = '{1'b0, OP_XOR, 8'hAA, 8'hFF, 8'h55, 4'b0000};
        vecs[11] = '{1'b1, OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b1000};
        vecs[12] = '{1'b0, OP_ADD, 8'h80, 8'h80, 8'h00, 4'b0111};

        // Reset held for two cycles, then released.
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", bus.req_ready_o, 2'b00);
        chk("rst_rsp_vld", bus.rsp_valid_o, 2'b00);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_res", bus.rsp_result_o, 8'h00);
        chk("rst_flags", bus.rsp_flags_o, 4'b0000);
        rst = 1'b0;
        tick();
        chk("idle_busy", bus.busy_o, 1'b0);
        chk("idle_rsp_vld", bus.rsp_valid_o, 2'b00);

        // Table of single transactions.
        for (int i = 0; i < 13; i++) begin
            run_txn(i, vecs[i]);
        end

        // r1 SUB with its response ready held low; r0's ready must be ignored.
        load(1'b1, OP_SUB, 8'h05, 8'h05);
        bus.req_valid_i = 2'b10;
        bus.rsp_ready_i = 2'b01;
        #1;
        chk("bp_ready", bus.req_ready_o, 2'b10);
        tick();
        bus.req_valid_i = 2'b00;
        #1;
        chk("bp_exec_vld", bus.rsp_valid_o, 2'b00);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_hold%0d_vld", k), bus.rsp_valid_o, 2'b10);
            chk($sformatf("bp_hold%0d_res", k), bus.rsp_result_o, 8'h00);
            chk($sformatf("bp_hold%0d_flags", k), bus.rsp_flags_o, 4'b0110);
            tick();
        end
        bus.rsp_ready_i = 2'b10;
        #1;
        chk("bp_release_vld", bus.rsp_valid_o, 2'b10);
        tick();
        chk("bp_done_vld", bus.rsp_valid_o, 2'b00);
        chk("bp_done_busy", bus.busy_o, 1'b0);

        // Both requesters continuously valid: grants alternate r0, r1, r0.
        c_gnt[0] = 1'b0; c_res[0] = 8'h0C; c_flags[0] = 4'b0000;
        c_gnt[1] = 1'b1; c_res[1] = 8'hF0; c_flags[1] = 4'b1000;
        c_gnt[2] = 1'b0; c_res[2] = 8'h0C; c_flags[2] = 4'b0000;
        load(1'b0, OP_SHL, 8'h03, 8'h02);
        load(1'b1, OP_NOT, 8'h0F, 8'h00);
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ct%0d_ready", k), bus.req_ready_o, 2'b01 << c_gnt[k]);
            tick();
            chk($sformatf("ct%0d_exec_ready", k), bus.req_ready_o, 2'b00);
            tick();
            chk($sformatf("ct%0d_rsp_vld", k), bus.rsp_valid_o, 2'b01 << c_gnt[k]);
            chk($sformatf("ct%0d_res", k), bus.rsp_result_o, c_res[k]);
            chk($sformatf("ct%0d_flags", k), bus.rsp_flags_o, c_flags[k]);
            chk($sformatf("ct%0d_rsp_ready", k), bus.req_ready_o, 2'b00);
            tick();
        end
        bus.req_valid_i = 2'b00;
        tick();

        // Reset during EXEC after an r0 grant (pointer now at r1).
        load(1'b0, OP_ADD, 8'h01, 8'h01);
        bus.req_valid_i = 2'b01;
        #1;
        chk("ra_ready", bus.req_ready_o, 2'b01);
        tick();
        bus.req_valid_i = 2'b00;
        rst = 1'b1;
        #1;
        chk("ra_busy", bus.busy_o, 1'b0);
        chk("ra_rsp_vld", bus.rsp_valid_o, 2'b00);
        chk("ra_res", bus.rsp_result_o, 8'h00);
        chk("ra_flags", bus.rsp_flags_o, 4'b0000);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ra_quiet%0d", k), bus.rsp_valid_o, 2'b00);
        end
        load(1'b0, OP_ADD, 8'h02, 8'h03);
        load(1'b1, OP_XOR, 8'h0F, 8'hF0);
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 2'b11;
        #1;
        chk("ra_rr_restart", bus.req_ready_o, 2'b01);
        tick();
        bus.req_valid_i = 2'b00;
        tick();
        chk("ra_next_vld", bus.rsp_valid_o, 2'b01);
        chk("ra_next_res", bus.rsp_result_o, 8'h05);
        chk("ra_next_flags", bus.rsp_flags_o, 4'b0000);
        tick();
        chk("ra_next_idle", bus.busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
